cmd_seq_checker: RTL
====================

// Module: cmd_seq_checker
// PURPOSE
// Synthesizable, parametrised command sequencer/checker for the KnightsTour BLE path.
// Queues (command, expected response) pairs, issues each command over the UART command
// interface, and waits for cmd_sent and then resp_rdy, each with a cycle timeout.
// Compares each response and clears it; keeps pass/fail counts.
// Sits between a host/BIST controller and the UART_wrapper-side cmd/resp ports.
// PARAMETERS
// CMD_W      16      command width
// RESP_W     8       response width
// DEPTH      8       queue entries (power of 2, >=2)
// TMO_W      17      timeout counter width
// TMO_CYC    100000  cycles allowed per wait phase (< 2**TMO_W)
// INTER_CODE 8'h5A   intermediate-response code (used only with SKIP_INTERMEDIATE_EN)
// PORTS
// clk        in   1       clock
// rst        in   1       synchronous reset, active-high
// push       in   1       enqueue {push_cmd,push_exp}; ignored when full
// push_cmd   in   CMD_W   command to queue
// push_exp   in   RESP_W  expected response for that command
// full       out  1       queue full
// start      in   1       begin draining queue; ignored unless idle
// busy       out  1       high from accepted start until done
// done       out  1       one-cycle pulse when run ends
// cmd        out  CMD_W   command to UART; stable from LOAD until next LOAD
// send_cmd   out  1       one-cycle send strobe
// cmd_sent   in   1       UART transmit-complete (rising edge used)
// resp       in   RESP_W  received response
// resp_rdy   in   1       response valid (level)
// clr_resp   out  1       one-cycle response clear
// pass_cnt   out  8       matches this run, saturating at 255
// fail_cnt   out  8       mismatches this run, saturating at 255
// tmo_err    out  1       sticky timeout flag, cleared by next accepted start
// last_resp  out  RESP_W  last checked response
// BEHAVIOUR
// - Interface decision: one clock clk; reset rst is synchronous and active-high.
// - Reset: all outputs 0; queue empty; FSM=IDLE; cmd_sent edge register=0.
// - Queue: circular, ptr width log2(DEPTH)+1; push legal any state incl. during run.
//   Simultaneous push+pop when full: pop occurs, push ignored (full sampled pre-edge).
// - FSM: IDLE -> LOAD -> SEND -> WAIT_SENT -> WAIT_RESP -> CHECK -> CLR -> (LOAD|DONE) -> IDLE.
//   IDLE: on start, clear pass/fail/tmo_err; if queue empty go DONE, else LOAD.
//   LOAD: pop head into cmd/exp registers.
//   SEND: send_cmd=1 (exactly one cycle); send_cmd rises 2 cycles after start edge.
//   WAIT_SENT: exit on cmd_sent 0->1.
//   WAIT_RESP: exit when resp_rdy=1.
//   CHECK: resp==exp -> pass_cnt++, else fail_cnt++; last_resp<=resp.
//   CLR: clr_resp=1 for one cycle; queue nonempty -> LOAD else DONE.
//   DONE: done=1 one cycle, busy=0 on next cycle.
// - Timeout: counter zeroed on entry to each WAIT_*; reaching TMO_CYC-1 without exit sets
//   tmo_err and fail_cnt++, flushes queue (rd_ptr<=wr_ptr), goes DONE; no clr_resp issued.
// - cmd_sent edge in the same cycle as timeout expiry: edge wins (no timeout).
// - busy=1 in every state except IDLE; start while busy ignored.
// - Counters saturate; never wrap.
// - rst mid-run: immediate return to reset state, queue discarded, send_cmd/clr_resp low.
// CONFIGURATION
// - Macro SKIP_INTERMEDIATE_EN defined: in WAIT_RESP, resp_rdy with resp==INTER_CODE
//   issues a one-cycle clr_resp, is not counted, leaves last_resp unchanged, restarts the
//   timeout counter, and stays in WAIT_RESP until a non-intermediate response.
// - Undefined: every response, including INTER_CODE, is checked against exp.
// TESTING
// - Push {16'h0000,8'hA5}, start; cmd_sent after 10 cycles; resp=A5 -> send_cmd 2 cyc after
//   start; pass_cnt=1, fail_cnt=0; clr_resp one pulse; done pulse.
// - Push 3 pairs (one with resp mismatch 8'h5A vs A5, macro off) -> pass=2, fail=1, cmds in FIFO order.
// - Never assert cmd_sent, TMO_CYC=100 -> tmo_err=1 at cycle 100 of WAIT_SENT;
//   fail=1; queue empty; done.
// - Macro on: send 16'h4022, return 5A, 5A, then A5 -> 3 clr_resp pulses; pass=1, fail=0.
// - Fill DEPTH entries, push once more -> ignored, full=1; start with empty queue -> done
//   pulse 1 cycle later, counts 0.
// - Assert rst during WAIT_RESP -> next cycle busy=0, full=0, counts 0, no send_cmd.

Source files
------------

// File: rtl/cmd_seq_if.sv
// cmd_seq_if: host-side queue/control and UART-side cmd/resp signals of cmd_seq_checker
interface cmd_seq_if #(parameter int CMD_W = 16, parameter int RESP_W = 8);
  logic push, full, start, busy, done, send_cmd, cmd_sent, resp_rdy, clr_resp, tmo_err;
  logic [CMD_W-1:0] push_cmd, cmd;
  logic [RESP_W-1:0] push_exp, resp, last_resp;
  logic [7:0] pass_cnt, fail_cnt;
  modport master(
    output push, push_cmd, push_exp, start, cmd_sent, resp, resp_rdy,
    input full, busy, done, cmd, send_cmd, clr_resp, pass_cnt, fail_cnt, tmo_err, last_resp
  );
  modport slave(
    input push, push_cmd, push_exp, start, cmd_sent, resp, resp_rdy,
    output full, busy, done, cmd, send_cmd, clr_resp, pass_cnt, fail_cnt, tmo_err, last_resp
  );
endinterface

// File: rtl/cmd_seq_checker.sv
// cmd_seq_checker: queued command issue and response checker; define SKIP_INTERMEDIATE_EN to skip INTER_CODE responses
module cmd_seq_checker #(
  parameter int CMD_W = 16,
  parameter int RESP_W = 8,
  parameter int DEPTH = 8,
  parameter int TMO_W = 17,
  parameter int TMO_CYC = 100000,
  parameter logic [RESP_W-1:0] INTER_CODE = 8'h5A
) (
  input logic clk,
  input logic rst,
  cmd_seq_if.slave bus
);
`ifdef SKIP_INTERMEDIATE_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK, CLR, DONE} state_t;
  state_t state;
  logic [CMD_W-1:0] cmd_mem [DEPTH];
  logic [RESP_W-1:0] exp_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [RESP_W-1:0] exp_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic sent_q, empty, sent_edge, tmo_hit, skip, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign bus.full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.busy = state != IDLE;
  assign do_push = bus.push && !bus.full;
  assign sent_edge = bus.cmd_sent && !sent_q;
  assign tmo_hit = tmo_cnt == TMO_W'(TMO_CYC - 1);
  assign skip = SKIP_EN && (bus.resp == INTER_CODE);
  always_ff @(posedge clk)
    if (do_push) begin
      cmd_mem[wr_ptr[AW-1:0]] <= bus.push_cmd;
      exp_mem[wr_ptr[AW-1:0]] <= bus.push_exp;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      exp_q <= '0;
      tmo_cnt <= '0;
      sent_q <= 1'b0;
      bus.cmd <= '0;
      bus.send_cmd <= 1'b0;
      bus.clr_resp <= 1'b0;
      bus.done <= 1'b0;
      bus.pass_cnt <= '0;
      bus.fail_cnt <= '0;
      bus.tmo_err <= 1'b0;
      bus.last_resp <= '0;
    end else begin
      sent_q <= bus.cmd_sent;
      bus.send_cmd <= state == SEND;
      bus.clr_resp <= 1'b0;
      bus.done <= 1'b0;
      tmo_cnt <= tmo_cnt + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE:
          if (bus.start) begin
            bus.pass_cnt <= '0;
            bus.fail_cnt <= '0;
            bus.tmo_err <= 1'b0;
            bus.done <= empty;
            state <= empty ? DONE : LOAD;
          end
        LOAD: begin
          bus.cmd <= cmd_mem[rd_ptr[AW-1:0]];
          exp_q <= exp_mem[rd_ptr[AW-1:0]];
          rd_ptr <= rd_ptr + 1'b1;
          state <= SEND;
        end
        SEND: begin
          tmo_cnt <= '0;
          state <= WAIT_SENT;
        end
        WAIT_SENT, WAIT_RESP:
          // A just-issued clr_resp has not reached the UART yet, so resp_rdy is stale that cycle
          if (state == WAIT_SENT ? sent_edge : (bus.resp_rdy && !bus.clr_resp)) begin
            tmo_cnt <= '0;
            if (state == WAIT_SENT) state <= WAIT_RESP;
            else if (skip) bus.clr_resp <= 1'b1;
            else state <= CHECK;
          end else if (tmo_hit) begin
            bus.tmo_err <= 1'b1;
            bus.fail_cnt <= (&bus.fail_cnt) ? bus.fail_cnt : bus.fail_cnt + 8'd1;
            rd_ptr <= wr_ptr;
            bus.done <= 1'b1;
            state <= DONE;
          end
        CHECK: begin
          if (bus.resp == exp_q) bus.pass_cnt <= (&bus.pass_cnt) ? bus.pass_cnt : bus.pass_cnt + 8'd1;
          else bus.fail_cnt <= (&bus.fail_cnt) ? bus.fail_cnt : bus.fail_cnt + 8'd1;
          bus.last_resp <= bus.resp;
          bus.clr_resp <= 1'b1;
          state <= CLR;
        end
        CLR: begin
          bus.done <= empty;
          state <= empty ? DONE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
